fsm_tx: RTL and testbench
=========================

# fsm_tx

UART transmit core: accepts a byte through a valid/ready handshake and serialises it onto the line as start bit, 8 data bits LSB first, optional parity bit and one stop bit. Bit timing comes from the shared baudrate generator's 16x acquisition tick. The block is the transmit-side counterpart of the Rx core state machine and shares its one-hot state encoding, so status logic can decode both directions identically. State, bit counter and tick counter are triplicated with majority voting for single-upset tolerance.

## Interface
- OVERSAMPLE, 16: AcqSig_i pulses per bit; legal range 4..16.
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- p_Enable_i  in  1  module enable; gates acceptance of new bytes only
- p_ParityEnable_i  in  1  1 = insert parity bit
- p_ParityOdd_i  in  1  1 = odd parity, 0 = even parity
- AcqSig_i  in  1  single-cycle tick at OVERSAMPLE x baudrate
- Data_i  in  8  byte to send
- DataValid_i  in  1  Data_i valid
- Ready_o  out  1  byte accepted when DataValid_i && Ready_o
- Tx_o  out  1  serial line, idle high, registered
- Done_o  out  1  one-cycle pulse at end of stop bit
- State_o  out  5  voted state: INTERVAL 00001, STARTBIT 00010, DATABITS 00100, PARITYBIT 01000, STOPBIT 10000
- BitCounter_o  out  4  voted data-bit index, 0 outside DATABITS

## Operation
- Reset values: State_o = INTERVAL, BitCounter_o = 0, Tx_o = 1, Done_o = 0, tick counter = 0, shift register = 0.
- bit_end = AcqSig_i && (tick counter == OVERSAMPLE-1). Tick counter increments on AcqSig_i in every state except INTERVAL; it clears to 0 on bit_end and on entering STARTBIT.
- Ready_o = p_Enable_i && (state == INTERVAL || (state == STOPBIT && bit_end)). Combinational.
- Capture: on accept, latch Data_i into the shift register and p_ParityEnable_i/p_ParityOdd_i into frame configuration. Compute parity = ^Data_i ^ p_ParityOdd_i. Go to STARTBIT.
- INTERVAL: Tx_o = 1. Exit only on accept.
- STARTBIT: Tx_o = 0. Go to DATABITS on bit_end.
- DATABITS: Tx_o = shift[0]. On bit_end, shift right and increment BitCounter. When bit_end occurs with BitCounter == 7, go to PARITYBIT if latched parity is enabled, else go to STOPBIT.
- PARITYBIT: Tx_o = latched parity bit. Go to STOPBIT on bit_end.
- STOPBIT: Tx_o = 1. On bit_end, pulse Done_o. Then go to STARTBIT if an accept occurs in the same cycle, else go to INTERVAL.
- p_Enable_i falling mid-frame: the current frame completes normally and no new byte is accepted.
- Changing Data_i or the parity inputs mid-frame has no effect on the current frame.
- Voting: each register copy is reloaded from the voted value every cycle, so a single upset is corrected in one cycle. A voted state that is not one-hot forces INTERVAL, Tx_o = 1, and the counters to 0.

## Timing
- Accept at cycle N: State_o = STARTBIT and Tx_o = 0 from N+1.
- Each bit lasts exactly OVERSAMPLE AcqSig_i pulses, measured from the first AcqSig_i after the state is entered.
- Tx_o and State_o change on the cycle after bit_end, always together.
- Done_o is high in the cycle after the final stop-bit bit_end.
- Back-to-back frames: the next start bit follows the stop bit with zero idle time.
- Frame length: 10 bits without parity, 11 bits with parity.
- rst asserted mid-frame: Tx_o = 1 immediately (asynchronous) and the frame is dropped. No Done_o is issued.

## Structure
- Shared package (uart_pkg): the five one-hot state constants, ENABLE/DISABLE, and the DATA_BITS = 8 constant, shared with the Rx core.
- Natural sub-module: tmr_voter, a parameterised-width bitwise majority voter instantiated for state (5), bit counter (4) and tick counter (4).
- Shift register, parity latch and Tx_o register sit in fsm_tx itself.

## Test plan
- Parity off, OVERSAMPLE 16, send 0xA5: Tx_o = 0,1,0,1,0,0,1,0,1,1, each bit held 16 ticks. Done_o pulses once; state returns to INTERVAL.
- Even parity, send 0x07: parity bit = 1. Odd parity, send 0x07: parity bit = 0. Both frames are 11 bits.
- Back-to-back: DataValid_i held high with 0x55 then 0xFF. Ready_o is high only in INTERVAL and on the final stop tick, and the second start bit immediately follows the first stop bit.
- p_Enable_i = 0 with DataValid_i = 1: Ready_o = 0 and Tx_o stays 1. Dropping enable mid-frame still completes the frame.
- Assert rst during data bit 3 of 0x00: Tx_o = 1 in the same cycle, state is INTERVAL, and no Done_o pulse.
- Force state copy A to 01000 during DATABITS: output is unchanged and copy A is corrected next cycle. Force all three copies to 00011: state goes to INTERVAL and Tx_o = 1.

Source files
------------

// File: rtl/uart_pkg.sv
// UART shared definitions: one-hot state encoding and frame constants
// common to the transmit and receive cores.
package uart_pkg;

   typedef enum logic [4:0] {
      ST_INTERVAL  = 5'b00001,
      ST_STARTBIT  = 5'b00010,
      ST_DATABITS  = 5'b00100,
      ST_PARITYBIT = 5'b01000,
      ST_STOPBIT   = 5'b10000
   } state_t;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   localparam int DATA_BITS = 8;

endpackage

// File: rtl/tmr_voter.sv
// Bitwise 2-of-3 majority voter for triplicated registers.
module tmr_voter #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] y
);

   assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/fsm_tx.sv
// UART transmit FSM: start, 8 data bits LSB first, optional parity, stop.
// State and both counters are triplicated and majority voted.
module fsm_tx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       p_Enable_i,
   input  logic       p_ParityEnable_i,
   input  logic       p_ParityOdd_i,
   input  logic       AcqSig_i,
   input  logic [7:0] Data_i,
   input  logic       DataValid_i,
   output logic       Ready_o,
   output logic       Tx_o,
   output logic       Done_o,
   output logic [4:0] State_o,
   output logic [3:0] BitCounter_o
);

   localparam logic [3:0] TICK_MAX = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   state_t     state_a, state_b, state_c;
   logic [3:0] bit_a, bit_b, bit_c;
   logic [3:0] tick_a, tick_b, tick_c;

   logic [4:0] state_raw;
   logic [3:0] bit_raw;
   logic [3:0] tick_raw;

   state_t     state_v;
   logic [3:0] bit_v;
   logic [3:0] tick_v;
   logic       state_ok;

   logic [7:0] shift_q;
   logic       par_en_q;
   logic       par_q;
   logic       tx_q;
   logic       done_q;

   state_t     state_n;
   logic [3:0] bit_n;
   logic [3:0] tick_n;
   logic [7:0] shift_n;
   logic       par_en_n;
   logic       par_n;
   logic       tx_n;
   logic       done_n;

   logic       bit_end;
   logic       ready;
   logic       accept;

   tmr_voter #(.WIDTH(5)) u_vote_state (
      .a (state_a),
      .b (state_b),
      .c (state_c),
      .y (state_raw)
   );

   tmr_voter #(.WIDTH(4)) u_vote_bit (
      .a (bit_a),
      .b (bit_b),
      .c (bit_c),
      .y (bit_raw)
   );

   tmr_voter #(.WIDTH(4)) u_vote_tick (
      .a (tick_a),
      .b (tick_b),
      .c (tick_c),
      .y (tick_raw)
   );

   // A corrupted (non one-hot) vote collapses to idle with cleared counters
   assign state_ok = $onehot(state_raw);
   assign state_v  = state_ok ? state_t'(state_raw) : ST_INTERVAL;
   assign bit_v    = state_ok ? bit_raw  : 4'd0;
   assign tick_v   = state_ok ? tick_raw : 4'd0;

   assign bit_end = AcqSig_i && (tick_v == TICK_MAX);

   assign ready = (p_Enable_i == ENABLE) &&
                  ((state_v == ST_INTERVAL) ||
                   ((state_v == ST_STOPBIT) && bit_end));

   assign accept = DataValid_i && ready;

   always_comb begin
      state_n  = state_v;
      bit_n    = bit_v;
      tick_n   = tick_v;
      shift_n  = shift_q;
      par_en_n = par_en_q;
      par_n    = par_q;
      done_n   = 1'b0;

      if (state_v != ST_INTERVAL && AcqSig_i)
         tick_n = tick_v + 4'd1;
      if (bit_end)
         tick_n = 4'd0;

      case (state_v)
         ST_INTERVAL: begin
            tick_n = 4'd0;
            bit_n  = 4'd0;
         end
         ST_STARTBIT: begin
            if (bit_end)
               state_n = ST_DATABITS;
         end
         ST_DATABITS: begin
            if (bit_end) begin
               shift_n = {1'b0, shift_q[7:1]};
               if (bit_v == LAST_BIT) begin
                  bit_n   = 4'd0;
                  state_n = par_en_q ? ST_PARITYBIT : ST_STOPBIT;
               end else begin
                  bit_n = bit_v + 4'd1;
               end
            end
         end
         ST_PARITYBIT: begin
            if (bit_end)
               state_n = ST_STOPBIT;
         end
         ST_STOPBIT: begin
            if (bit_end) begin
               done_n  = 1'b1;
               state_n = ST_INTERVAL;
            end
         end
         default: begin
            state_n = ST_INTERVAL;
            bit_n   = 4'd0;
            tick_n  = 4'd0;
         end
      endcase

      // Accept is only possible from idle or the last stop tick
      if (accept) begin
         state_n  = ST_STARTBIT;
         bit_n    = 4'd0;
         tick_n   = 4'd0;
         shift_n  = Data_i;
         par_en_n = p_ParityEnable_i;
         par_n    = ^Data_i ^ p_ParityOdd_i;
      end

      case (state_n)
         ST_STARTBIT:  tx_n = 1'b0;
         ST_DATABITS:  tx_n = shift_n[0];
         ST_PARITYBIT: tx_n = par_n;
         default:      tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_a  <= ST_INTERVAL;
         state_b  <= ST_INTERVAL;
         state_c  <= ST_INTERVAL;
         bit_a    <= 4'd0;
         bit_b    <= 4'd0;
         bit_c    <= 4'd0;
         tick_a   <= 4'd0;
         tick_b   <= 4'd0;
         tick_c   <= 4'd0;
         shift_q  <= 8'd0;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
         tx_q     <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_a  <= state_n;
         state_b  <= state_n;
         state_c  <= state_n;
         bit_a    <= bit_n;
         bit_b    <= bit_n;
         bit_c    <= bit_n;
         tick_a   <= tick_n;
         tick_b   <= tick_n;
         tick_c   <= tick_n;
         shift_q  <= shift_n;
         par_en_q <= par_en_n;
         par_q    <= par_n;
         tx_q     <= tx_n;
         done_q   <= done_n;
      end
   end

   assign Ready_o      = ready;
   assign Tx_o         = tx_q;
   assign Done_o       = done_q;
   assign State_o      = state_v;
   assign BitCounter_o = bit_v;

endmodule

// File: tb/tb_fsm_tx.sv
// Directed bench for fsm_tx: frame table, back-to-back, enable,
// reset and TMR fault sequences.
module tb_fsm_tx;
   import uart_pkg::*;

   localparam int OS = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       p_Enable_i = 1'b1;
   logic       p_ParityEnable_i = 1'b0;
   logic       p_ParityOdd_i = 1'b0;
   logic       AcqSig_i = 1'b0;
   logic [7:0] Data_i = 8'h00;
   logic       DataValid_i = 1'b0;
   logic       Ready_o;
   logic       Tx_o;
   logic       Done_o;
   logic [4:0] State_o;
   logic [3:0] BitCounter_o;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   int rdy_cnt = 0;
   logic [4:0] rdy_state = 5'd0;
   bit mon_en = 1'b0;
   bit acq_tog = 1'b0;

   fsm_tx #(.OVERSAMPLE(OS)) dut (
      .clk              (clk),
      .rst              (rst),
      .p_Enable_i       (p_Enable_i),
      .p_ParityEnable_i (p_ParityEnable_i),
      .p_ParityOdd_i    (p_ParityOdd_i),
      .AcqSig_i         (AcqSig_i),
      .Data_i           (Data_i),
      .DataValid_i      (DataValid_i),
      .Ready_o          (Ready_o),
      .Tx_o             (Tx_o),
      .Done_o           (Done_o),
      .State_o          (State_o),
      .BitCounter_o     (BitCounter_o)
   );

   always #5 clk = ~clk;

   // Tick on every second clock, updated just after the rising edge
   always @(posedge clk) begin
      #1;
      AcqSig_i = acq_tog;
      acq_tog  = ~acq_tog;
   end

   always @(negedge clk) begin
      if (Done_o)
         done_cnt++;
      if (mon_en && Ready_o) begin
         rdy_cnt++;
         rdy_state = State_o;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [7:0]  data;
      logic        pen;
      logic        podd;
      logic [10:0] frame;
      int          nbits;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_tick();
      int n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (AcqSig_i !== 1'b1 && n < 8);
      if (AcqSig_i !== 1'b1)
         chk("tick_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (Ready_o !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (Ready_o !== 1'b1)
         chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic start_frame(input logic [7:0] d, input logic pen,
                              input logic podd);
      wait_ready();
      Data_i           = d;
      p_ParityEnable_i = pen;
      p_ParityOdd_i    = podd;
      DataValid_i      = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_frame(input vec_t v, input bit chained,
                            input bit hold_valid, input logic [7:0] nxt,
                            input bit drop_en, input logic [4:0] end_st);
      if (!chained)
         start_frame(v.data, v.pen, v.podd);
      if (hold_valid) begin
         Data_i = nxt;
      end else begin
         DataValid_i   = 1'b0;
         Data_i        = ~v.data;
         p_ParityOdd_i = ~v.podd;
      end
      if (drop_en)
         p_Enable_i = 1'b0;
      chk("start_state", 32'(State_o), 32'(ST_STARTBIT));
      for (int b = 0; b < v.nbits; b++) begin
         for (int t = 0; t < OS; t++) begin
            if (t == 0 || t == OS - 1)
               chk($sformatf("tx_%02h_bit%0d_t%0d", v.data, b, t),
                   32'(Tx_o), 32'(v.frame[b]));
            wait_tick();
         end
      end
      chk("done_pulse", 32'(Done_o), 32'd1);
      chk("end_state", 32'(State_o), 32'(end_st));
   endtask

   initial begin
      vec_t v;
      int d0;
      int bad;

      vecs[0] = '{8'hA5, 1'b0, 1'b0, 11'b11101001010, 10};
      vecs[1] = '{8'h07, 1'b1, 1'b0, 11'b11000001110, 11};
      vecs[2] = '{8'h07, 1'b1, 1'b1, 11'b10000001110, 11};
      vecs[3] = '{8'h00, 1'b1, 1'b1, 11'b11000000000, 11};
      vecs[4] = '{8'h80, 1'b1, 1'b0, 11'b11100000000, 11};
      vecs[5] = '{8'h3C, 1'b0, 1'b0, 11'b11001111000, 10};

      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(Tx_o), 32'd1);
      chk("rst_state", 32'(State_o), 32'(ST_INTERVAL));
      chk("rst_bitcnt", 32'(BitCounter_o), 32'd0);
      chk("rst_done", 32'(Done_o), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_ready", 32'(Ready_o), 32'd1);

      for (int i = 0; i < 6; i++) begin
         d0 = done_cnt;
         run_frame(vecs[i], 1'b0, 1'b0, 8'h00, 1'b0, ST_INTERVAL);
         repeat (4) @(negedge clk);
         chk("done_once", done_cnt, d0 + 1);
         chk("idle_tx", 32'(Tx_o), 32'd1);
      end

      // back-to-back 0x55 then 0xFF with valid held high
      v = '{8'h55, 1'b0, 1'b0, 11'b11010101010, 10};
      start_frame(v.data, v.pen, v.podd);
      rdy_cnt = 0;
      mon_en  = 1'b1;
      run_frame(v, 1'b1, 1'b1, 8'hFF, 1'b0, ST_STARTBIT);
      mon_en = 1'b0;
      DataValid_i = 1'b0;
      chk("b2b_ready_count", rdy_cnt, 1);
      chk("b2b_ready_state", 32'(rdy_state), 32'(ST_STOPBIT));
      v = '{8'hFF, 1'b0, 1'b0, 11'b11111111110, 10};
      run_frame(v, 1'b1, 1'b0, 8'h00, 1'b0, ST_INTERVAL);

      // enable low blocks acceptance
      p_Enable_i  = 1'b0;
      DataValid_i = 1'b1;
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (Ready_o !== 1'b0 || Tx_o !== 1'b1)
            bad++;
      end
      chk("disabled_idle", bad, 0);
      chk("disabled_state", 32'(State_o), 32'(ST_INTERVAL));
      DataValid_i = 1'b0;
      p_Enable_i  = 1'b1;
      @(negedge clk);

      // enable dropped mid-frame, valid kept high: frame completes, no reaccept
      run_frame(vecs[5], 1'b0, 1'b1, 8'h99, 1'b1, ST_INTERVAL);
      repeat (4) @(negedge clk);
      chk("drop_en_idle", 32'(State_o), 32'(ST_INTERVAL));
      DataValid_i = 1'b0;
      p_Enable_i  = 1'b1;
      @(negedge clk);

      // reset during data bit 3 of 0x00
      start_frame(8'h00, 1'b0, 1'b0);
      DataValid_i = 1'b0;
      repeat (OS * 4 + 8) wait_tick();
      chk("pre_rst_state", 32'(State_o), 32'(ST_DATABITS));
      chk("pre_rst_bitcnt", 32'(BitCounter_o), 32'd3);
      chk("pre_rst_tx", 32'(Tx_o), 32'd0);
      d0 = done_cnt;
      rst = 1'b1;
      #1;
      chk("async_rst_tx", 32'(Tx_o), 32'd1);
      chk("async_rst_state", 32'(State_o), 32'(ST_INTERVAL));
      chk("async_rst_bitcnt", 32'(BitCounter_o), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("rst_no_done", done_cnt, d0);

      // single-copy upset during DATABITS
      start_frame(8'h00, 1'b0, 1'b0);
      DataValid_i = 1'b0;
      repeat (OS + 8) wait_tick();
      force dut.state_a = ST_PARITYBIT;
      #1;
      chk("seu_state_out", 32'(State_o), 32'(ST_DATABITS));
      chk("seu_tx", 32'(Tx_o), 32'd0);
      release dut.state_a;
      @(posedge clk);
      #2;
      chk("seu_corrected", 32'(dut.state_a), 32'(ST_DATABITS));
      chk("seu_state_after", 32'(State_o), 32'(ST_DATABITS));
      @(negedge clk);

      // all copies corrupted to a non one-hot code
      d0 = done_cnt;
      force dut.state_a = state_t'(5'b00011);
      force dut.state_b = state_t'(5'b00011);
      force dut.state_c = state_t'(5'b00011);
      #1;
      chk("bad_state_out", 32'(State_o), 32'(ST_INTERVAL));
      chk("bad_state_bitcnt", 32'(BitCounter_o), 32'd0);
      release dut.state_a;
      release dut.state_b;
      release dut.state_c;
      @(posedge clk);
      #2;
      chk("bad_state_recover", 32'(dut.state_a), 32'(ST_INTERVAL));
      chk("bad_state_tx", 32'(Tx_o), 32'd1);
      repeat (40) @(negedge clk);
      chk("bad_state_no_done", done_cnt, d0);
      chk("bad_state_idle", 32'(State_o), 32'(ST_INTERVAL));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
